riscv_lsu: RTL

//  Load/store unit sitting directly downstream of the instruction decoder. It consumes
//  mem_req / mem_we / mem_size and the ALU-computed address, and runs one data-memory

---
 rtl/riscv_lsu_pkg.sv | 50 +++++
 rtl/riscv_lsu_load_ext.sv | 26 ++
 rtl/riscv_lsu.sv | 99 +++++++++
 3 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load/store unit: decoder size codes, FSM states and
// the lane helpers used when a request is accepted.
package riscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_e;

  // Unsigned variants only make sense for loads.
  function automatic logic size_legal(input logic [2:0] size, input logic we);
    case (size)
      LDST_B, LDST_H, LDST_W: return 1'b1;
      LDST_BU, LDST_HU:       return ~we;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic addr_aligned(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      LDST_H, LDST_HU: return ~lo[0];
      LDST_W:          return lo == 2'b00;
      default:         return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      LDST_B, LDST_BU: return 4'b0001 << lo;
      LDST_H, LDST_HU: return 4'b0011 << {lo[1], 1'b0};
      default:         return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] size, input logic [31:0] d);
    case (size)
      LDST_B:  return {4{d[7:0]}};
      LDST_H:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_load_ext.sv
// Selects the addressed byte/halfword lane of a read word and sign- or zero-extends it.
module riscv_lsu_load_ext
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rd,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rd[8*addr_lo +: 8];
    half_lane = addr_lo[1] ? rd[31:16] : rd[15:0];
    case (size)
      LDST_B:  data = {{24{byte_lane[7]}}, byte_lane};
      LDST_BU: data = {24'd0, byte_lane};
      LDST_H:  data = {{16{half_lane[15]}}, half_lane};
      LDST_HU: data = {16'd0, half_lane};
      default: data = rd;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one data-memory transaction per accepted request, stalling the core
// until completion and flagging misaligned or illegal-size accesses.
module riscv_lsu
  import riscv_lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_valid_o,
  output logic        lsu_stall_o,
  output logic        lsu_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i,
  output logic [1:0]  dbg_state
);

  // Memory handshake: mem_req_o rises on entry to ACCESS and every mem_* output stays
  // frozen until the cycle mem_ready_i is high; that cycle completes the transfer.

  lsu_state_e  state, state_next;
  logic        err_pending;
  logic        req_ok;
  logic        accept;
  logic [2:0]  size_q;
  logic [1:0]  lo_q;
  logic [31:0] ext_data;

  assign req_ok = size_legal(lsu_size_i, lsu_we_i) && addr_aligned(lsu_size_i, lsu_addr_i[1:0]);
  // The error cycle also blocks acceptance so a held request cannot re-fire at once.
  assign accept = (state == ST_IDLE) && !err_pending && lsu_req_i && req_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept) state_next = ST_ACCESS;
      ST_ACCESS: if (mem_ready_i) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_pending <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= 4'd0;
      mem_addr_o  <= 32'd0;
      mem_wd_o    <= 32'd0;
      lsu_data_o  <= 32'd0;
      size_q      <= 3'd0;
      lo_q        <= 2'd0;
    end else begin
      err_pending <= (state == ST_IDLE) && !err_pending && lsu_req_i && !req_ok;
      if (accept) begin
        mem_req_o  <= 1'b1;
        mem_we_o   <= lsu_we_i;
        mem_be_o   <= byte_en(lsu_size_i, lsu_addr_i[1:0]);
        mem_addr_o <= {lsu_addr_i[31:2], 2'b00};
        mem_wd_o   <= store_lanes(lsu_size_i, lsu_data_i);
        size_q     <= lsu_size_i;
        lo_q       <= lsu_addr_i[1:0];
      end else if (state == ST_ACCESS && mem_ready_i) begin
        mem_req_o <= 1'b0;
        mem_we_o  <= 1'b0;
        mem_be_o  <= 4'd0;
        if (!mem_we_o) lsu_data_o <= ext_data;
      end
    end
  end

  riscv_lsu_load_ext u_load_ext (
    .size    (size_q),
    .addr_lo (lo_q),
    .rd      (mem_rd_i),
    .data    (ext_data)
  );

  assign lsu_valid_o = (state == ST_DONE);
  assign lsu_err_o   = err_pending;
  assign lsu_stall_o = lsu_req_i && (state != ST_DONE) && !err_pending;
  assign dbg_state   = state;

endmodule
